// File: rtl/vec_normalize.sv
`default_nettype none
// ============================================================================
//  Module   : vec_normalize
//  Purpose  : Normalizes a 3-component fixed-point vector to unit length.
//             Phases: SQ (sum of squares) -> RT (radix-4 square root)
//             -> DV (per-component divide) -> DONE (hold until out_ready).
//  Options  : VEC_NORMALIZE_SAT_EN - saturate the square accumulator at
//             2^(WIDTH-1)-1 instead of wrapping modulo 2^(WIDTH-1).
//  Revision : 1.0 - initial release
// ============================================================================
module vec_normalize #(
  parameter int WIDTH = 32,
  parameter int BF    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_z,
  output logic [WIDTH-1:0] out_len,
  output logic             out_zero
);

  // Root bits produced: one per radix-4 iteration.
  localparam int ITER = WIDTH - (WIDTH - BF) / 2;
  // Magnitude bits of a component and of the accumulator.
  localparam int MW   = WIDTH - 1;
  // Radicand is sum << BF, left-padded to a whole number of bit pairs.
  localparam int RADW = 2 * ITER;
  localparam int PADW = RADW - MW - BF;
  // Dividend width for (|c| << BF).
  localparam int NUMW = MW + BF;
  localparam int CW   = $clog2(ITER + 1);

  localparam logic [WIDTH-1:0] c_min = {1'b1, {MW{1'b0}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ   = 3'd1,
    RT   = 3'd2,
    DV   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_x;
  logic [WIDTH-1:0]  r_y;
  logic [WIDTH-1:0]  r_z;
  logic [MW-1:0]     r_sum;
  logic [RADW-1:0]   r_rad;
  logic [ITER+1:0]   r_rem;
  logic [ITER-1:0]   r_root;
  logic [WIDTH-1:0]  r_ox;
  logic [WIDTH-1:0]  r_oy;
  logic [WIDTH-1:0]  r_oz;
  logic              r_zero;

  // Shared component path (SQ and DV both walk x, y, z by r_cnt).
  logic [WIDTH-1:0]  w_comp;
  logic              w_neg;
  logic [WIDTH-1:0]  w_negated;
  logic [MW-1:0]     w_mag;

  // Square / accumulate.
  logic [2*MW-1:0]   w_sq_full;
  logic [2*MW-1:0]   w_sq;
  logic [MW:0]       w_add;
  logic [MW-1:0]     w_sum_nx;

  // Square-root iteration.
  logic [1:0]        w_pair;
  logic [ITER+1:0]   w_rem_sh;
  logic [ITER+1:0]   w_trial;
  logic              w_ge;
  logic [ITER+1:0]   w_rem_nx;
  logic [ITER-1:0]   w_root_nx;

  // Divide.
  logic [NUMW-1:0]   w_num;
  logic [NUMW-1:0]   w_den;
  logic [NUMW-1:0]   w_quo;
  logic [WIDTH-1:0]  w_quo_w;
  logic [WIDTH-1:0]  w_res;

  logic              w_unused;

  // Select the component addressed by the phase counter.
  always_comb begin
    w_comp = r_z;
    if (r_cnt == CW'(0)) begin
      w_comp = r_x;
    end else if (r_cnt == CW'(1)) begin
      w_comp = r_y;
    end
  end

  // The most negative value has no positive twin; clamp it to the largest
  // representable magnitude.
  assign w_neg     = w_comp[WIDTH-1];
  assign w_negated = -w_comp;
  assign w_mag     = (w_comp == c_min) ? {MW{1'b1}}
                   : (w_neg ? w_negated[MW-1:0] : w_comp[MW-1:0]);

  assign w_sq_full = {{MW{1'b0}}, w_mag} * {{MW{1'b0}}, w_mag};
  assign w_sq      = w_sq_full >> BF;
  assign w_add     = {1'b0, r_sum} + {1'b0, w_sq[MW-1:0]};

`ifdef VEC_NORMALIZE_SAT_EN
  // Any square or partial sum that does not fit in MW bits pins the sum.
  assign w_sum_nx  = ((|w_sq[2*MW-1:MW]) || w_add[MW]) ? {MW{1'b1}} : w_add[MW-1:0];
`else
  // Modular accumulation: high bits of the square and the carry are dropped.
  assign w_sum_nx  = w_add[MW-1:0];
`endif

  // Restoring radix-4 step: bring down two radicand bits, try 4*root+1.
  assign w_pair    = r_rad[RADW-1 -: 2];
  assign w_rem_sh  = {r_rem[ITER-1:0], w_pair};
  assign w_trial   = {r_root, 2'b01};
  assign w_ge      = (w_rem_sh >= w_trial);
  assign w_rem_nx  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
  assign w_root_nx = {r_root[ITER-2:0], w_ge};

  // Magnitude divide; quotients wider than WIDTH keep only their low bits.
  assign w_num     = {w_mag, {BF{1'b0}}};
  assign w_den     = NUMW'(r_root);
  assign w_quo     = w_num / w_den;
  assign w_quo_w   = w_quo[WIDTH-1:0];
  assign w_res     = w_neg ? (-w_quo_w) : w_quo_w;

  assign w_unused  = ^{r_rem[ITER+1:ITER], w_negated[WIDTH-1], w_quo[NUMW-1:WIDTH],
                       w_sq[2*MW-1:MW], w_add[MW]};

  assign out_x     = r_ox;
  assign out_y     = r_oy;
  assign out_z     = r_oz;
  assign out_len   = WIDTH'(r_root);
  assign out_zero  = r_zero;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nx = r_state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nx = SQ;
        end
      end
      SQ: begin
        if (r_cnt == CW'(2)) begin
          w_state_nx = RT;
        end
      end
      RT: begin
        if (r_cnt == CW'(ITER - 1)) begin
          w_state_nx = (w_root_nx == '0) ? DONE : DV;
        end
      end
      DV: begin
        if (r_cnt == CW'(2)) begin
          w_state_nx = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nx = IDLE;
        end
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  // Datapath: capture, accumulate, root iterations and component divides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_sum  <= '0;
      r_rad  <= '0;
      r_rem  <= '0;
      r_root <= '0;
      r_ox   <= '0;
      r_oy   <= '0;
      r_oz   <= '0;
      r_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && in_ready) begin
            r_x    <= in_x;
            r_y    <= in_y;
            r_z    <= in_z;
            r_cnt  <= '0;
            r_sum  <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_ox   <= '0;
            r_oy   <= '0;
            r_oz   <= '0;
            r_zero <= 1'b0;
          end
        end
        SQ: begin
          r_sum <= w_sum_nx;
          if (r_cnt == CW'(2)) begin
            r_rad <= {{PADW{1'b0}}, w_sum_nx, {BF{1'b0}}};
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RT: begin
          r_rad  <= r_rad << 2;
          r_rem  <= w_rem_nx;
          r_root <= w_root_nx;
          if (r_cnt == CW'(ITER - 1)) begin
            r_cnt <= '0;
            if (w_root_nx == '0) begin
              r_zero <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DV: begin
          case (r_cnt)
            CW'(0):  r_ox <= w_res;
            CW'(1):  r_oy <= w_res;
            default: r_oz <= w_res;
          endcase
          r_cnt <= r_cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
